// File: rtl/ex_stage_mc.sv
// ex_stage_mc: parameterised execute stage with ranked forwarding and the EX/MEM register folded in.
// Define EX_MULDIV_EN to build the iterative mul/div engine with HI/LO; without it ops 11-14 retire as no-write bubbles.

module ex_fwd_sel #(
    parameter int WIDTH  = 32,
    parameter int NUM_FW = 2
) (
    input  logic [4:0]              src,
    input  logic [WIDTH-1:0]        rd,
    input  logic [NUM_FW-1:0]       fwValid,
    input  logic [NUM_FW*5-1:0]     fwReg,
    input  logic [NUM_FW*WIDTH-1:0] fwData,
    output logic [WIDTH-1:0]        opnd
);
    // Walk from oldest to youngest so the lowest matching index overrides.
    always_comb begin
        opnd = rd;
        for (int i = NUM_FW-1; i >= 0; i--) begin
            if (fwValid[i] && (fwReg[i*5 +: 5] == src) && (src != 5'd0))
                opnd = fwData[i*WIDTH +: WIDTH];
        end
    end
endmodule

module ex_stage_mc #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_FW = 2,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Flush,
    input  logic                    InValid,
    input  logic [3:0]              InOp,
    input  logic [4:0]              InSrcA,
    input  logic [4:0]              InSrcB,
    input  logic [WIDTH-1:0]        InRD1,
    input  logic [WIDTH-1:0]        InRD2,
    input  logic [WIDTH-1:0]        InImm,
    input  logic                    InUseImm,
    input  logic [SHW-1:0]          InShamt,
    input  logic [4:0]              InDest,
    input  logic                    InWrite,
    input  logic [NUM_FW-1:0]       FWValid,
    input  logic [NUM_FW*5-1:0]     FWReg,
    input  logic [NUM_FW*WIDTH-1:0] FWData,
    output logic                    Stall,
    output logic                    OutValid,
    output logic                    OutWrite,
    output logic                    OutZero,
    output logic [4:0]              OutDest,
    output logic [WIDTH-1:0]        OutResult
);
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MFLO, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI
    } exOp_e;

    typedef struct packed {
        logic             valid;
        logic             write;
        logic             zero;
        logic [4:0]       dest;
        logic [WIDTH-1:0] result;
    } exOut_t;

    logic [1:0][4:0]       srcIdx;
    logic [1:0][WIDTH-1:0] rdData;
    logic [1:0][WIDTH-1:0] fwOpnd;
    logic [WIDTH-1:0]      opA, opB;

    assign srcIdx = {InSrcB, InSrcA};
    assign rdData = {InRD2, InRD1};

    for (genvar g = 0; g < 2; g++) begin : gFwd
        ex_fwd_sel #(.WIDTH(WIDTH), .NUM_FW(NUM_FW)) uSel (
            .src    (srcIdx[g]),
            .rd     (rdData[g]),
            .fwValid(FWValid),
            .fwReg  (FWReg),
            .fwData (FWData),
            .opnd   (fwOpnd[g])
        );
    end

    assign opA = fwOpnd[0];
    assign opB = InUseImm ? InImm : fwOpnd[1];

    exOp_e            op;
    logic             isMulDiv, accept;
    logic [WIDTH-1:0] hiVal, loVal, aluRes;

    assign op       = exOp_e'(InOp);
    assign isMulDiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign accept   = InValid & ~Stall & ~Flush;

    always_comb begin
        aluRes = '0;
        case (op)
            OP_ADD:  aluRes = opA + opB;
            OP_SUB:  aluRes = opA - opB;
            OP_AND:  aluRes = opA & opB;
            OP_OR:   aluRes = opA | opB;
            OP_XOR:  aluRes = opA ^ opB;
            OP_MFLO: aluRes = loVal;
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, opA < opB};
            OP_SLL:  aluRes = opA << InShamt;
            OP_SRL:  aluRes = opA >> InShamt;
            OP_SRA:  aluRes = $signed(opA) >>> InShamt;
            OP_MFHI: aluRes = hiVal;
            default: aluRes = '0;
        endcase
    end

    exOut_t outQ, outD;

    // Bubbles keep the old result/dest but never advertise valid or write.
    always_comb begin
        outD       = outQ;
        outD.valid = 1'b0;
        outD.write = 1'b0;
        if (accept) begin
            outD.valid  = 1'b1;
            outD.write  = InWrite & ~isMulDiv;
            outD.dest   = InDest;
            outD.result = aluRes;
            outD.zero   = (aluRes == '0);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) outQ <= '0;
        else        outQ <= outD;
    end

    assign OutValid  = outQ.valid;
    assign OutWrite  = outQ.write;
    assign OutZero   = outQ.zero;
    assign OutDest   = outQ.dest;
    assign OutResult = outQ.result;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} mdState_e;

    mdState_e           state, stateNxt;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc, accStep, prodFix;
    logic [WIDTH-1:0]   absA, absB, hiQ, loQ;
    logic [WIDTH-1:0]   absAIn, absBIn, mulAdd, fixHi, fixLo;
    logic [WIDTH:0]     mulSum, divShift, divTrial;
    logic               negA, negB, isDiv;
    logic               issue, sgnOp, negAIn, negBIn, isDivIn;

    assign issue   = accept & isMulDiv;
    assign sgnOp   = (op == OP_MULT) || (op == OP_DIV);
    assign isDivIn = (op == OP_DIV) || (op == OP_DIVU);
    assign negAIn  = sgnOp & opA[WIDTH-1];
    assign negBIn  = sgnOp & opB[WIDTH-1];
    assign absAIn  = negAIn ? -opA : opA;
    assign absBIn  = negBIn ? -opB : opB;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        if (Flush) stateNxt = S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (issue) stateNxt = S_RUN;
                S_RUN:   if (cnt == '1) stateNxt = S_FIX;
                S_FIX:   stateNxt = S_IDLE;
                default: stateNxt = S_IDLE;
            endcase
        end
    end

    // Shared {hi,lo} shifter: shift-add for multiply, restoring division for divide.
    assign mulAdd   = acc[0] ? absA : '0;
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mulAdd};
    assign divShift = acc[2*WIDTH-1:WIDTH-1];
    assign divTrial = divShift - {1'b0, absB};

    always_comb begin
        if (!isDiv)              accStep = {mulSum, acc[WIDTH-1:1]};
        else if (!divTrial[WIDTH]) accStep = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                     accStep = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign prodFix = (negA ^ negB) ? -acc : acc;

    always_comb begin
        fixHi = prodFix[2*WIDTH-1:WIDTH];
        fixLo = prodFix[WIDTH-1:0];
        if (isDiv) begin
            if (absB == '0) begin
                fixLo = '1;
                fixHi = negA ? -absA : absA;
            end else begin
                fixLo = (negA ^ negB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                fixHi = negA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt   <= '0;
            acc   <= '0;
            absA  <= '0;
            absB  <= '0;
            negA  <= 1'b0;
            negB  <= 1'b0;
            isDiv <= 1'b0;
            hiQ   <= '0;
            loQ   <= '0;
        end else if (issue) begin
            cnt   <= '0;
            absA  <= absAIn;
            absB  <= absBIn;
            negA  <= negAIn;
            negB  <= negBIn;
            isDiv <= isDivIn;
            acc   <= {{WIDTH{1'b0}}, (isDivIn ? absAIn : absBIn)};
        end else if (state == S_RUN && !Flush) begin
            acc <= accStep;
            cnt <= cnt + 1'b1;
        end else if (state == S_FIX && !Flush) begin
            hiQ <= fixHi;
            loQ <= fixLo;
        end
    end

    assign Stall = (state != S_IDLE);
    assign hiVal = hiQ;
    assign loVal = loQ;
`else
    assign Stall = 1'b0;
    assign hiVal = '0;
    assign loVal = '0;
`endif

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: forwarding, ALU corners, bubbles/flush, and mul/div when EX_MULDIV_EN is set.

module tb_ex_stage_mc;
    logic        Clock = 1'b0;
    logic        Reset, Flush, InValid, InUseImm, InWrite, Stall;
    logic [3:0]  InOp;
    logic [4:0]  InSrcA, InSrcB, InDest, OutDest;
    logic [31:0] InRD1, InRD2, InImm, OutResult;
    logic [4:0]  InShamt;
    logic [1:0]  FWValid;
    logic [9:0]  FWReg;
    logic [63:0] FWData;
    logic        OutValid, OutWrite, OutZero;

    int checks   = 0;
    int failures = 0;

    ex_stage_mc #(.WIDTH(32), .NUM_FW(2)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InOp(InOp),
        .InSrcA(InSrcA), .InSrcB(InSrcB), .InRD1(InRD1), .InRD2(InRD2), .InImm(InImm),
        .InUseImm(InUseImm), .InShamt(InShamt), .InDest(InDest), .InWrite(InWrite),
        .FWValid(FWValid), .FWReg(FWReg), .FWData(FWData), .Stall(Stall),
        .OutValid(OutValid), .OutWrite(OutWrite), .OutZero(OutZero),
        .OutDest(OutDest), .OutResult(OutResult)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        InValid  = 1'b1;
        InOp     = op;
        InSrcA   = 5'd1;
        InSrcB   = 5'd2;
        InRD1    = a;
        InRD2    = b;
        InUseImm = 1'b0;
        InWrite  = 1'b1;
        InDest   = 5'd9;
        FWValid  = 2'b00;
    endtask

`ifdef EX_MULDIV_EN
    // Issue a mul/div, then idle until Stall drops; returns how many samples saw Stall high.
    task automatic runMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(op, a, b);
        tick();
        InValid = 1'b0;
        n = 0;
        while (Stall && n < 100) begin
            n++;
            tick();
        end
    endtask
`endif

    initial begin
        Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; InOp = 4'd0; InSrcA = '0; InSrcB = '0;
        InRD1 = '0; InRD2 = '0; InImm = '0; InUseImm = 1'b0; InShamt = '0; InDest = '0;
        InWrite = 1'b0; FWValid = '0; FWReg = '0; FWData = '0;
        #22;
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_result", OutResult, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_misc", {24'd0, OutWrite, OutZero, OutDest}, 32'd0);
        Reset = 1'b1;
        tick();

        // Forwarding: index 0 beats index 1; src 0 is never forwarded; imm never forwarded
        drive(4'd0, 32'd100, 32'd1);
        InSrcA = 5'd5; InSrcB = 5'd3; InDest = 5'd4;
        FWValid = 2'b11; FWReg = {5'd5, 5'd5}; FWData = {32'd9, 32'd7};
        tick();
        chk("fw_prio", OutResult, 32'd8);
        chk("fw_flags", {29'd0, OutValid, OutWrite, OutZero}, 32'b110);
        chk("fw_dest", {27'd0, OutDest}, 32'd4);
        InSrcA = 5'd0;
        tick();
        chk("fw_src0", OutResult, 32'd101);
        InSrcA = 5'd5; FWValid = 2'b10;
        tick();
        chk("fw_idx1", OutResult, 32'd10);
        InSrcA = 5'd0; InSrcB = 5'd5; FWValid = 2'b11;
        tick();
        chk("fw_b", OutResult, 32'd107);
        InUseImm = 1'b1; InImm = 32'd20;
        tick();
        chk("fw_imm", OutResult, 32'd120);

        // ALU corners
        drive(4'd1, 32'd0, 32'd1);
        tick();
        chk("sub_wrap", OutResult, 32'hFFFF_FFFF);
        chk("sub_wrap_z", {31'd0, OutZero}, 32'd0);
        drive(4'd1, 32'd5, 32'd5);
        tick();
        chk("sub_zero_z", {31'd0, OutZero}, 32'd1);
        drive(4'd6, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt", OutResult, 32'd1);
        drive(4'd7, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("sltu", OutResult, 32'd0);
        drive(4'd10, 32'h8000_0000, 32'h8000_0000);
        InShamt = 5'd31;
        tick();
        chk("sra", OutResult, 32'hFFFF_FFFF);
        InOp = 4'd9;
        tick();
        chk("srl", OutResult, 32'd1);
        drive(4'd8, 32'd1, 32'd1);
        InShamt = 5'd4;
        tick();
        chk("sll", OutResult, 32'd16);
        drive(4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        tick();
        chk("and", OutResult, 32'h00F0_000F);
        InOp = 4'd3;
        tick();
        chk("or", OutResult, 32'hFFF0_0FFF);
        InOp = 4'd4;
        tick();
        chk("xor", OutResult, 32'hFF00_0FF0);
        drive(4'd0, 32'd2, 32'd3);
        InWrite = 1'b0;
        tick();
        chk("nowrite", {30'd0, OutValid, OutWrite}, 32'b10);

        // Bubble and flush
        InValid = 1'b0;
        tick();
        chk("bubble", {31'd0, OutValid}, 32'd0);
        drive(4'd0, 32'd2, 32'd3);
        Flush = 1'b1;
        tick();
        chk("flush_kill", {30'd0, OutValid, OutWrite}, 32'd0);
        Flush = 1'b0;

`ifdef EX_MULDIV_EN
        begin
            int n;
            runMd(4'd11, 32'hFFFF_FFFD, 32'd5, n);
            chk("mult_stall", n, 32'd33);
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("mult_lo", OutResult, 32'hFFFF_FFF1);
            InOp = 4'd15;
            tick();
            chk("mult_hi", OutResult, 32'hFFFF_FFFF);

            runMd(4'd13, 32'hFFFF_FFF9, 32'd2, n);
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("div_lo", OutResult, 32'hFFFF_FFFD);
            InOp = 4'd15;
            tick();
            chk("div_hi", OutResult, 32'hFFFF_FFFF);

            runMd(4'd14, 32'd10, 32'd0, n);
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("divz_lo", OutResult, 32'hFFFF_FFFF);
            InOp = 4'd15;
            tick();
            chk("divz_hi", OutResult, 32'd10);

            runMd(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, n);
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("ovf_lo", OutResult, 32'h8000_0000);
            InOp = 4'd15;
            tick();
            chk("ovf_hi", OutResult, 32'd0);

            // Flush mid-RUN: HI/LO keep the overflow-divide results
            drive(4'd12, 32'd3, 32'd4);
            tick();
            InValid = 1'b0;
            chk("multu_issue", {30'd0, OutValid, OutWrite}, 32'b10);
            for (int i = 0; i < 10; i++) tick();
            chk("multu_busy", {31'd0, Stall}, 32'd1);
            Flush = 1'b1;
            tick();
            Flush = 1'b0;
            chk("flush_stall", {31'd0, Stall}, 32'd0);
            chk("flush_valid", {31'd0, OutValid}, 32'd0);
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("flush_lo", OutResult, 32'h8000_0000);
            InOp = 4'd15;
            tick();
            chk("flush_hi", OutResult, 32'd0);

            // Async reset mid-RUN
            drive(4'd12, 32'd3, 32'd4);
            tick();
            InValid = 1'b0;
            for (int i = 0; i < 10; i++) tick();
            #2 Reset = 1'b0;
            #1;
            chk("arst_stall", {31'd0, Stall}, 32'd0);
            chk("arst_out", {OutValid, OutWrite, OutZero, OutDest, OutResult[23:0]}, 32'd0);
            chk("arst_res", OutResult, 32'd0);
            #10 Reset = 1'b1;
            drive(4'd5, 32'd0, 32'd0);
            tick();
            chk("arst_lo", OutResult, 32'd0);
        end
`else
        drive(4'd11, 32'hFFFF_FFFD, 32'd5);
        tick();
        chk("nomd_mult_stall", {31'd0, Stall}, 32'd0);
        chk("nomd_mult_out", {30'd0, OutValid, OutWrite}, 32'b10);
        InOp = 4'd15;
        InWrite = 1'b1;
        tick();
        chk("nomd_mfhi_stall", {31'd0, Stall}, 32'd0);
        chk("nomd_mfhi_valid", {31'd0, OutValid}, 32'd1);
        chk("nomd_mfhi", OutResult, 32'd0);
        chk("nomd_mfhi_z", {31'd0, OutZero}, 32'd1);
        InOp = 4'd5;
        tick();
        chk("nomd_mflo", OutResult, 32'd0);
`endif

        InValid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised multi-cycle execute stage for the pipelined core, sitting between ID/EX and EX/MEM. It generalises the single-cycle execute path in three ways: configurable datapath width, N ranked forwarding sources, and an iterative multiply/divide engine with HI/LO registers. The engine stalls upstream while it runs. All results are registered, so the EX/MEM boundary register lives inside this block.

## Interface
- `WIDTH`, 32: datapath width; must be ≥8 and a power of two.
- `NUM_FW`, 2: number of forwarding sources; index 0 is the youngest and has the highest priority.
- `SHW`, $clog2(WIDTH): shift-amount width (localparam).

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Flush`  in  1  kills the incoming instruction and aborts any running mul/div.
- `InValid`  in  1  instruction present.
- `InOp`  in  4  operation code:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MFLO, 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI
- `InSrcA`, `InSrcB`  in  5  source register indices.
- `InRD1`, `InRD2`  in  WIDTH  register-file read data.
- `InImm`  in  WIDTH  sign-extended immediate.
- `InUseImm`  in  1  B operand = InImm. The immediate is never forwarded.
- `InShamt`  in  SHW  shift amount.
- `InDest`  in  5  destination register.
- `InWrite`  in  1  instruction writes a register.
- `FWValid`  in  NUM_FW  per-source write enable.
- `FWReg`  in  NUM_FW*5  per-source destination index.
- `FWData`  in  NUM_FW*WIDTH  per-source data.
- `Stall`  out  1  upstream must hold; inputs are ignored.
- `OutValid`, `OutWrite`, `OutZero`  out  1  registered result flags.
- `OutDest`  out  5  registered destination.
- `OutResult`  out  WIDTH  registered result.

## Operation
- **Forwarding.** For each operand, select the lowest index i such that `FWValid[i]` is set, `FWReg[i]` equals the source index, and the source index is not 0. Otherwise use InRD1/InRD2.
- **Accept.** An instruction is accepted when `InValid & !Stall & !Flush`.
- **Single-cycle ops.**
  - Result is registered at the accepting edge.
  - Arithmetic is modulo 2^WIDTH.
  - SLT is signed and SLTU is unsigned; both return 0 or 1.
  - Shifts use InShamt; SRA is arithmetic.
- **MFHI/MFLO** return HI/LO as they stand at acceptance.
- **Mul/div issue** (ops 11–14):
  - Accepted only from IDLE.
  - Registers `OutValid=1, OutWrite=0`.
  - Latches the absolute values of the operands and their signs, then enters RUN.
- **FSM: IDLE → RUN → FIX → IDLE.**
  - RUN lasts exactly WIDTH cycles: radix-2 shift-add for multiply, restoring division for divide.
  - FIX applies the sign correction and writes HI/LO.
  - Multiply: {HI,LO} = full 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN / −1: LO = MIN, HI = 0.
- **Stall** = (state ≠ IDLE). This is combinational from the state register.
- **Flush** in any state:
  - Returns the FSM to IDLE at the next edge.
  - HI/LO are unchanged.
  - The next edge registers OutValid = 0.
- **Bubbles.** OutValid = 0 on every edge with no accept.
- **OutZero** = (OutResult == 0) and is valid only when OutValid is high.

## Timing
- **Reset values.**
  - All outputs are 0, so Stall = 0.
  - HI = LO = 0; FSM is IDLE; internal accumulators are 0.
- **Single-cycle op latency:** 1 clock from accept to Out*.
- **Mul/div:**
  - Stall is high for WIDTH+1 cycles after the issue edge (WIDTH RUN + 1 FIX).
  - HI/LO are updated at the edge leaving FIX.
  - An MFHI/MFLO held during the stall is accepted in the first IDLE cycle and sees the new values.
- **Forwarding is combinational.** The forwarding inputs are sampled in the same cycle as accept.
- **Reset mid-operation** aborts immediately (asynchronous). No HI/LO write occurs.
- **Flush and accept in the same cycle:** Flush wins.
- **Back-to-back mul/div:** the second is accepted on the first cycle after FIX.

## Configuration
- `EX_MULDIV_EN` defined:
  - Mul/div engine, HI/LO and FSM are present, as described above.
- `EX_MULDIV_EN` undefined:
  - No FSM and no HI/LO; Stall is tied to 0.
  - Ops 11–14 complete in 1 cycle with OutValid=1, OutWrite=0.
  - MFHI/MFLO return 0.

## Test plan
- **Forwarding priority.** InSrcA=5, FWReg={5,5}, FWData[0]=7, FWData[1]=9, both valid. ADD with RD2=1 → OutResult=8. Repeat with InSrcA=0 → RD1 is used.
- **ALU corners.**
  - SUB 0−1 → 0xFFFFFFFF, OutZero=0.
  - SLT 0xFFFFFFFF,1 → 1; SLTU with the same operands → 0.
  - SRA 0x80000000 by 31 → 0xFFFFFFFF.
- **MULT.** −3 × 5 → Stall high for exactly 33 cycles. The following MFLO returns 0xFFFFFFF1 and MFHI returns 0xFFFFFFFF.
- **DIV.**
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 10 / 0 → LO=0xFFFFFFFF, HI=10.
  - 0x80000000 / −1 → LO=0x80000000, HI=0.
- **Abort cases.**
  - Flush asserted on RUN cycle 10 of MULTU → Stall drops the next cycle; HI/LO retain their previous values.
  - Same scenario with Reset pulled low instead → all outputs are 0 immediately.
- **Compile without `EX_MULDIV_EN`.** MULT, then MFHI → Stall never rises; OutValid=1 both cycles; MFHI result = 0.
